// File: rtl/pipelined_cla_adder_if.sv
// Stream bundle for pipelined_cla_adder: operand beat in, flagged result out.
// Both channels use valid/ready: a beat transfers on a rising clk edge where valid & ready are both 1; a source must hold its beat stable until then.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor; groups of BLOCK bits are spread
// evenly over STAGES register stages, with the running carry registered between stages.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int GROUPS = WIDTH / BLOCK;
  localparam int GPS    = GROUPS / STAGES;

  // Operands travel whole; each stage only consumes the groups it resolves.
  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cy;
    logic             am;
    logic             bm;
  } stage_t;

  stage_t st_in  [STAGES];
  stage_t pipe_d [STAGES];
  stage_t pipe_q [STAGES];
  logic   ovf_d, ovf_q;
  logic   zero_d, zero_q;
  logic   adv;

  assign adv = ~pipe_q[STAGES-1].vld | bus.out_ready;

  always_comb begin : stage_inputs
    for (int s = 0; s < STAGES; s++) begin
      st_in[s] = '0;
    end
    st_in[0].vld = bus.in_valid;
    st_in[0].opa = bus.a;
    st_in[0].opb = bus.sub ? ~bus.b : bus.b;
    st_in[0].cy  = bus.sub ^ bus.cin;
    st_in[0].am  = bus.a[WIDTH-1];
    st_in[0].bm  = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
    for (int s = 1; s < STAGES; s++) begin
      st_in[s] = pipe_q[s-1];
    end
  end

  always_comb begin : stage_logic
    logic c;
    logic bc;
    logic gp;
    logic gg;
    logic p;
    logic gn;
    int   base;
    c      = 1'b0;
    bc     = 1'b0;
    gp     = 1'b0;
    gg     = 1'b0;
    p      = 1'b0;
    gn     = 1'b0;
    base   = 0;
    ovf_d  = 1'b0;
    zero_d = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      pipe_d[s] = st_in[s];
      c = st_in[s].cy;
      for (int k = 0; k < GPS; k++) begin
        base = (s * GPS + k) * BLOCK;
        gp = 1'b1;
        gg = 1'b0;
        bc = c;
        for (int i = 0; i < BLOCK; i++) begin
          p  = st_in[s].opa[base + i] ^ st_in[s].opb[base + i];
          gn = st_in[s].opa[base + i] & st_in[s].opb[base + i];
          pipe_d[s].sum[base + i] = p ^ bc;
          bc = gn | (p & bc);
          gg = gn | (p & gg);
          gp = gp & p;
        end
        // Group-level lookahead carries the chain to the next group.
        c = gg | (gp & c);
      end
      pipe_d[s].cy = c;
    end
    zero_d = ~|pipe_d[STAGES-1].sum;
    ovf_d  = (pipe_d[STAGES-1].am == pipe_d[STAGES-1].bm) &
             (pipe_d[STAGES-1].sum[WIDTH-1] != pipe_d[STAGES-1].am);
  end

  // One global enable: the whole pipe moves or the whole pipe holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_q[s] <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int s = 0; s < STAGES; s++) begin
        pipe_q[s] <= pipe_d[s];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = pipe_q[STAGES-1].vld;
  assign bus.sum       = pipe_q[STAGES-1].sum;
  assign bus.cout      = pipe_q[STAGES-1].cy;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: 32-bit default instance plus
// 8-bit STAGES=1 and STAGES=2 instances swept against a behavioural model.
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [34:0] m_q[$];
  logic [34:0] s1_q[$];
  logic [34:0] s2_q[$];

  pipelined_cla_adder_if #(.WIDTH(32)) m_if ();
  pipelined_cla_adder_if #(.WIDTH(8))  s1_if ();
  pipelined_cla_adder_if #(.WIDTH(8))  s2_if ();

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .bus(s1_if.slave));
  pipelined_cla_adder #(.WIDTH(8), .BLOCK(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .bus(s2_if.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: {cout, overflow, zero, sum} for a w-bit operation.
  function automatic logic [34:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] mask;
    logic [31:0] be;
    logic [31:0] s;
    logic [32:0] t;
    logic        co;
    logic        ov;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    be   = (sub ? ~b : b) & mask;
    t    = {1'b0, a & mask} + {1'b0, be} + {32'b0, sub ^ cin};
    s    = t[31:0] & mask;
    co   = t[w];
    ov   = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    return {co, ov, (s == 32'd0), s};
  endfunction

  // Scoreboards: at negedge, inputs and out_ready are stable for the coming edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_if.out_valid && m_if.out_ready) begin
        if (m_q.size() == 0) chk("m_unexpected_out", 64'(m_if.sum), 64'hDEAD);
        else chk("m_result", 64'({m_if.cout, m_if.overflow, m_if.zero, m_if.sum}), 64'(m_q.pop_front()));
      end
      if (m_if.in_valid && m_if.in_ready)
        m_q.push_back(model(32, m_if.a, m_if.b, m_if.cin, m_if.sub));
      if (s1_if.out_valid && s1_if.out_ready) begin
        if (s1_q.size() == 0) chk("s1_unexpected_out", 64'(s1_if.sum), 64'hDEAD);
        else chk("s1_result", 64'({s1_if.cout, s1_if.overflow, s1_if.zero, 24'h0, s1_if.sum}), 64'(s1_q.pop_front()));
      end
      if (s1_if.in_valid && s1_if.in_ready)
        s1_q.push_back(model(8, 32'(s1_if.a), 32'(s1_if.b), s1_if.cin, s1_if.sub));
      if (s2_if.out_valid && s2_if.out_ready) begin
        if (s2_q.size() == 0) chk("s2_unexpected_out", 64'(s2_if.sum), 64'hDEAD);
        else chk("s2_result", 64'({s2_if.cout, s2_if.overflow, s2_if.zero, 24'h0, s2_if.sum}), 64'(s2_q.pop_front()));
      end
      if (s2_if.in_valid && s2_if.in_ready)
        s2_q.push_back(model(8, 32'(s2_if.a), 32'(s2_if.b), s2_if.cin, s2_if.sub));
    end
  end

  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
    m_if.a = a; m_if.b = b; m_if.cin = cin; m_if.sub = sub;
    m_if.in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(m_if.in_ready), 64'd1);
    tick();
    m_if.in_valid = 1'b0;
    #1;
    chk({tag, "_lat1_idle"}, 64'(m_if.out_valid), 64'd0);
    tick();
    chk({tag, "_lat2_valid"}, 64'(m_if.out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(m_if.sum), 64'(es));
    chk({tag, "_cout"}, 64'(m_if.cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(m_if.overflow), 64'(eo));
    chk({tag, "_zero"}, 64'(m_if.zero), 64'(ez));
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.cin = 1'b0; m_if.sub = 1'b0; m_if.out_ready = 1'b1;
    s1_if.in_valid = 1'b0; s1_if.a = '0; s1_if.b = '0; s1_if.cin = 1'b0; s1_if.sub = 1'b0; s1_if.out_ready = 1'b1;
    s2_if.in_valid = 1'b0; s2_if.a = '0; s2_if.b = '0; s2_if.cin = 1'b0; s2_if.sub = 1'b0; s2_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
    chk("rst_sum", 64'(m_if.sum), 64'd0);
    chk("rst_cout", 64'(m_if.cout), 64'd0);
    chk("rst_ovf", 64'(m_if.overflow), 64'd0);
    chk("rst_zero", 64'(m_if.zero), 64'd0);
    chk("rst_in_ready", 64'(m_if.in_ready), 64'd1);
    rst_n = 1'b1;
    tick();

    single("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    single("add_wrap",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("sub_neg",    32'd5,         32'd7,         1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    single("sub_ovf",    32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    single("sub_borrow", 32'd10,        32'd3,         1'b1, 1'b1, 32'd6,         1'b1, 1'b0, 1'b0);
    single("add_cin",    32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0, 1'b0);
    single("add_chain",  32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    single("sub_zero",   32'd0,         32'd0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);

    // Backpressure: four beats, output stalled for three cycles at first out_valid.
    m_if.out_ready = 1'b1; m_if.b = 32'h10; m_if.cin = 1'b0; m_if.sub = 1'b0;
    m_if.a = 32'd1; m_if.in_valid = 1'b1;
    tick();
    m_if.a = 32'd2;
    #1;
    chk("bp_lat_idle", 64'(m_if.out_valid), 64'd0);
    tick();
    m_if.a = 32'd3;
    chk("bp_first_valid", 64'(m_if.out_valid), 64'd1);
    m_if.out_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      chk("bp_in_ready_low", 64'(m_if.in_ready), 64'd0);
      chk("bp_hold_valid", 64'(m_if.out_valid), 64'd1);
      chk("bp_hold_sum", 64'(m_if.sum), 64'h11);
      tick();
    end
    m_if.out_ready = 1'b1;
    tick();
    m_if.a = 32'd4;
    tick();
    m_if.in_valid = 1'b0;
    repeat (4) tick();
    chk("bp_drained", 64'(m_q.size()), 64'd0);
    chk("bp_idle_after", 64'(m_if.out_valid), 64'd0);

    // Reset pulse between edges with two beats in flight.
    m_if.a = 32'd3; m_if.b = 32'd4; m_if.in_valid = 1'b1;
    tick();
    m_if.a = 32'd5;
    tick();
    m_if.in_valid = 1'b0;
    chk("rstmid_pre_valid", 64'(m_if.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_out_valid", 64'(m_if.out_valid), 64'd0);
    chk("rstmid_sum", 64'(m_if.sum), 64'd0);
    chk("rstmid_cout", 64'(m_if.cout), 64'd0);
    chk("rstmid_ovf", 64'(m_if.overflow), 64'd0);
    chk("rstmid_zero", 64'(m_if.zero), 64'd0);
    chk("rstmid_in_ready", 64'(m_if.in_ready), 64'd1);
    rst_n = 1'b1;
    m_q.delete();
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("rstmid_no_ghost", 64'(m_if.out_valid), 64'd0);
    end
    single("post_rst", 32'h0000_0100, 32'h0000_00FF, 1'b0, 1'b0, 32'h0000_01FF, 1'b0, 1'b0, 1'b0);

    // Small instances: latency 1 and 2.
    s1_if.a = 8'h12; s1_if.b = 8'h34; s1_if.in_valid = 1'b1;
    s2_if.a = 8'h80; s2_if.b = 8'h80; s2_if.in_valid = 1'b1;
    tick();
    s1_if.in_valid = 1'b0;
    s2_if.in_valid = 1'b0;
    chk("s1_lat1_valid", 64'(s1_if.out_valid), 64'd1);
    chk("s1_lat1_sum", 64'(s1_if.sum), 64'h46);
    chk("s2_lat1_idle", 64'(s2_if.out_valid), 64'd0);
    tick();
    chk("s1_after_idle", 64'(s1_if.out_valid), 64'd0);
    chk("s2_lat2_valid", 64'(s2_if.out_valid), 64'd1);
    chk("s2_lat2_sum", 64'(s2_if.sum), 64'h00);
    chk("s2_lat2_cout", 64'(s2_if.cout), 64'd1);
    chk("s2_lat2_ovf", 64'(s2_if.overflow), 64'd1);
    chk("s2_lat2_zero", 64'(s2_if.zero), 64'd1);
    tick();

    // Sweep: all a, sixteen spread b values, every cin/sub, random out_ready.
    fork
      begin
        bit acc;
        int tries;
        for (int i = 0; i < 256; i++)
          for (int j = 0; j < 16; j++)
            for (int k = 0; k < 4; k++) begin
              s1_if.a = 8'(i); s1_if.b = 8'(j * 17); s1_if.cin = k[0]; s1_if.sub = k[1];
              s1_if.in_valid = 1'b1;
              acc = 1'b0;
              tries = 0;
              while (!acc && tries < 64) begin
                s1_if.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = s1_if.in_ready;
                tries++;
                @(posedge clk);
                #1;
              end
              if (!acc) chk("s1_accept_timeout", 64'(acc), 64'd1);
            end
        s1_if.in_valid = 1'b0;
        s1_if.out_ready = 1'b1;
      end
      begin
        bit acc;
        int tries;
        for (int i = 0; i < 256; i++)
          for (int j = 0; j < 16; j++)
            for (int k = 0; k < 4; k++) begin
              s2_if.a = 8'(i); s2_if.b = 8'(j * 17); s2_if.cin = k[0]; s2_if.sub = k[1];
              s2_if.in_valid = 1'b1;
              acc = 1'b0;
              tries = 0;
              while (!acc && tries < 64) begin
                s2_if.out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = s2_if.in_ready;
                tries++;
                @(posedge clk);
                #1;
              end
              if (!acc) chk("s2_accept_timeout", 64'(acc), 64'd1);
            end
        s2_if.in_valid = 1'b0;
        s2_if.out_ready = 1'b1;
      end
    join
    repeat (10) tick();
    chk("s1_queue_empty", 64'(s1_q.size()), 64'd0);
    chk("s2_queue_empty", 64'(s2_q.size()), 64'd0);
    chk("m_queue_empty", 64'(m_q.size()), 64'd0);
    chk("s1_final_idle", 64'(s1_if.out_valid), 64'd0);
    chk("s2_final_idle", 64'(s2_if.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
